// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared pipeline types and constants
package cpu_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      KILL  = 2'd1,
      HOLD  = 2'd2
   } fetch_state_e;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
   localparam logic [31:0] PC_INCR   = 32'd4;

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] addr;
   } if_id_t;

endpackage

// File: rtl/if_id_pipe_reg.sv
// rtl/if_id_pipe_reg.sv - 64-bit stage register with flush > hold > load priority
module if_id_pipe_reg #(
   parameter logic [63:0] FLUSH_VALUE = 64'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        hold,
   input  logic        load,
   input  logic [63:0] d,
   output logic [63:0] q
);

   logic [63:0] q_d;
   logic [63:0] q_q;

   always_comb begin
      q_d = q_q;
      if (flush) begin
         q_d = FLUSH_VALUE;
      end else if (!hold && load) begin
         q_d = d;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         q_q <= FLUSH_VALUE;
      end else begin
         q_q <= q_d;
      end
   end

   assign q = q_q;

endmodule

// File: rtl/if_fetch_stage.sv
// rtl/if_fetch_stage.sv - instruction fetch: PC, imem req/ready handshake, IF/ID register
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        Stall,
   input  logic        Redirect,
   input  logic [31:0] Redirect_address,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] Instruction_ID,
   output logic [31:0] Address_ID,
   output logic [31:0] PC
);

   import cpu_pkg::*;

   fetch_state_e state_d, state_q;
   logic [31:0]  pc_d, pc_q;
   logic [31:0]  kill_addr_d, kill_addr_q;
   if_id_t       hold_buf_d, hold_buf_q;
   logic         req_d, req_q;
   logic [31:0]  addr_d, addr_q;

   logic         completion;
   logic [31:0]  pc_plus4;
   logic [31:0]  redir_pc;
   logic         ifid_flush, ifid_hold, ifid_load;
   if_id_t       ifid_din, ifid_q;

   // The request is gated by reset so a half-finished request vanishes immediately.
   assign imem_req   = req_q & ~reset;
   assign imem_addr  = addr_q;
   assign completion = imem_req & imem_ready;
   assign pc_plus4   = pc_q + PC_INCR;
   assign redir_pc   = Redirect_address & ~32'd3;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      kill_addr_d = kill_addr_q;
      hold_buf_d  = hold_buf_q;
      ifid_flush  = 1'b0;
      ifid_hold   = 1'b0;
      ifid_load   = 1'b0;
      ifid_din    = '{instr: imem_rdata, addr: pc_plus4};

      if (Redirect) begin
         pc_d       = redir_pc;
         ifid_flush = 1'b1;
         unique case (state_q)
            FETCH: begin
               if (!completion) begin
                  kill_addr_d = pc_q;
                  state_d     = KILL;
               end
            end
            HOLD:    state_d = FETCH;
            KILL:    state_d = completion ? FETCH : KILL;
            default: state_d = FETCH;
         endcase
      end else begin
         unique case (state_q)
            FETCH: begin
               if (completion) begin
                  pc_d = pc_plus4;
                  if (Stall) begin
                     hold_buf_d = '{instr: imem_rdata, addr: pc_plus4};
                     ifid_hold  = 1'b1;
                     state_d    = HOLD;
                  end else begin
                     ifid_load = 1'b1;
                  end
               end else if (Stall) begin
                  ifid_hold = 1'b1;
               end else begin
                  ifid_flush = 1'b1;
               end
            end
            HOLD: begin
               ifid_din = hold_buf_q;
               if (Stall) begin
                  ifid_hold = 1'b1;
               end else begin
                  ifid_load = 1'b1;
                  state_d   = FETCH;
               end
            end
            KILL: begin
               if (completion) state_d = FETCH;
               if (Stall) ifid_hold = 1'b1;
               else       ifid_flush = 1'b1;
            end
            default: state_d = FETCH;
         endcase
      end

      // Request and address are registered from the next state so they are stable for a whole cycle.
      req_d  = (state_d != HOLD);
      addr_d = (state_d == KILL) ? kill_addr_d : pc_d;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         kill_addr_q <= RESET_PC;
         hold_buf_q  <= '{instr: NOP_INSTR, addr: 32'h0};
         req_q       <= 1'b1;
         addr_q      <= RESET_PC;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         kill_addr_q <= kill_addr_d;
         hold_buf_q  <= hold_buf_d;
         req_q       <= req_d;
         addr_q      <= addr_d;
      end
   end

   if_id_pipe_reg #(
      .FLUSH_VALUE({NOP_INSTR, 32'h0})
   ) u_if_id (
      .clock (clock),
      .reset (reset),
      .flush (ifid_flush),
      .hold  (ifid_hold),
      .load  (ifid_load),
      .d     (ifid_din),
      .q     (ifid_q)
   );

   assign Instruction_ID = ifid_q.instr;
   assign Address_ID     = ifid_q.addr;
   assign PC             = pc_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// tb/tb_if_fetch_stage.sv - directed bench for if_fetch_stage
module tb_if_fetch_stage;

   logic        clock = 1'b0;
   logic        reset;
   logic        Stall;
   logic        Redirect;
   logic [31:0] Redirect_address;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] Instruction_ID;
   logic [31:0] Address_ID;
   logic [31:0] PC;

   int total = 0;
   int bad   = 0;

   if_fetch_stage dut (
      .clock            (clock),
      .reset            (reset),
      .Stall            (Stall),
      .Redirect         (Redirect),
      .Redirect_address (Redirect_address),
      .imem_req         (imem_req),
      .imem_addr        (imem_addr),
      .imem_ready       (imem_ready),
      .imem_rdata       (imem_rdata),
      .Instruction_ID   (Instruction_ID),
      .Address_ID       (Address_ID),
      .PC               (PC)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      case (a)
         32'h0000_0000: mem_word = 32'h2008_000A;
         32'h0000_0004: mem_word = 32'h2009_0005;
         32'h0000_0008: mem_word = 32'h0109_5020;
         32'h0000_0010: mem_word = 32'h8D0B_0000;
         32'h0000_0018: mem_word = 32'hDEAD_BEEF;
         32'h0000_0040: mem_word = 32'h1111_1111;
         32'h0000_0044: mem_word = 32'h2222_2222;
         32'hFFFF_FFFC: mem_word = 32'hAAAA_5555;
         default:       mem_word = {16'hC0DE, a[15:0]};
      endcase
   endfunction

   always_comb imem_rdata = mem_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset = 1'b1; Stall = 1'b0; Redirect = 1'b0;
      Redirect_address = 32'h0; imem_ready = 1'b1;

      // reset
      step();
      chk("rst_req", {31'b0, imem_req}, 32'd0);
      chk("rst_instr", Instruction_ID, 32'h0);
      chk("rst_addr", Address_ID, 32'h0);
      chk("rst_pc", PC, 32'h0);
      reset = 1'b0;
      #1;
      chk("first_req", {31'b0, imem_req}, 32'd1);
      chk("first_addr", imem_addr, 32'h0);

      // zero-wait stream
      step();
      chk("zw0_instr", Instruction_ID, 32'h2008_000A);
      chk("zw0_addr", Address_ID, 32'h4);
      step();
      chk("zw1_instr", Instruction_ID, 32'h2009_0005);
      chk("zw1_addr", Address_ID, 32'h8);
      step();
      chk("zw2_instr", Instruction_ID, 32'h0109_5020);
      chk("zw2_addr", Address_ID, 32'hC);
      chk("zw2_pc", PC, 32'hC);

      // 2-cycle latency
      imem_ready = 1'b0;
      step();
      chk("lat_bubble", Instruction_ID, 32'h0);
      chk("lat_bubble_addr", Address_ID, 32'h0);
      chk("lat_pc", PC, 32'hC);
      chk("lat_imem_addr", imem_addr, 32'hC);
      chk("lat_req", {31'b0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      step();
      chk("lat_instr", Instruction_ID, 32'hC0DE_000C);
      chk("lat_addr", Address_ID, 32'h10);
      chk("lat_pc2", PC, 32'h10);

      // stall coinciding with completion at 0x10
      Stall = 1'b1;
      step();
      chk("stall1_instr", Instruction_ID, 32'hC0DE_000C);
      chk("stall1_req", {31'b0, imem_req}, 32'd0);
      chk("stall1_pc", PC, 32'h14);
      step();
      chk("stall2_instr", Instruction_ID, 32'hC0DE_000C);
      step();
      chk("stall3_instr", Instruction_ID, 32'hC0DE_000C);
      Stall = 1'b0;
      step();
      chk("unstall_instr", Instruction_ID, 32'h8D0B_0000);
      chk("unstall_addr", Address_ID, 32'h14);
      chk("unstall_imem_addr", imem_addr, 32'h14);
      chk("unstall_req", {31'b0, imem_req}, 32'd1);
      step();
      chk("f14_instr", Instruction_ID, 32'hC0DE_0014);
      chk("f14_pc", PC, 32'h18);

      // redirect while request to 0x18 pending
      imem_ready = 1'b0;
      step();
      chk("pend18_instr", Instruction_ID, 32'h0);
      Redirect = 1'b1; Redirect_address = 32'h0000_0043;
      step();
      Redirect = 1'b0;
      chk("redir_pc", PC, 32'h40);
      chk("redir_instr", Instruction_ID, 32'h0);
      chk("kill_addr", imem_addr, 32'h18);
      chk("kill_req", {31'b0, imem_req}, 32'd1);
      imem_ready = 1'b1;
      step();
      chk("kill_drop", Instruction_ID, 32'h0);
      chk("after_kill_addr", imem_addr, 32'h40);
      step();
      chk("f40_instr", Instruction_ID, 32'h1111_1111);
      chk("f40_addr", Address_ID, 32'h44);

      // redirect + stall while in HOLD
      Stall = 1'b1;
      step();
      chk("hold_instr", Instruction_ID, 32'h1111_1111);
      chk("hold_pc", PC, 32'h48);
      Redirect = 1'b1; Redirect_address = 32'hFFFF_FFFC;
      step();
      chk("hredir_instr", Instruction_ID, 32'h0);
      chk("hredir_addr_id", Address_ID, 32'h0);
      chk("hredir_pc", PC, 32'hFFFF_FFFC);
      chk("hredir_req", {31'b0, imem_req}, 32'd1);
      chk("hredir_imem_addr", imem_addr, 32'hFFFF_FFFC);
      Redirect = 1'b0; Stall = 1'b0;

      // PC wrap
      step();
      chk("wrap_instr", Instruction_ID, 32'hAAAA_5555);
      chk("wrap_addr_id", Address_ID, 32'h0);
      chk("wrap_pc", PC, 32'h0);
      step();
      chk("post_wrap_instr", Instruction_ID, 32'h2008_000A);
      chk("post_wrap_pc", PC, 32'h4);

      // reset during a wait
      imem_ready = 1'b0;
      step();
      chk("wait4_imem_addr", imem_addr, 32'h4);
      reset = 1'b1;
      #1;
      chk("midrst_req", {31'b0, imem_req}, 32'd0);
      step();
      chk("midrst_pc", PC, 32'h0);
      chk("midrst_instr", Instruction_ID, 32'h0);
      reset = 1'b0; imem_ready = 1'b1;
      #1;
      chk("postrst_imem_addr", imem_addr, 32'h0);
      chk("postrst_req", {31'b0, imem_req}, 32'd1);
      step();
      chk("postrst_instr", Instruction_ID, 32'h2008_000A);
      chk("postrst_addr_id", Address_ID, 32'h4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
